// File: rtl/soc_timer_pkg.sv
// soc_timer_pkg: register map offsets and CTRL bit positions for the timer bank.
// No ports; imported by soc_timer_chan and soc_timer_bank.
package soc_timer_pkg;
    localparam int unsigned REG_CYCLES = 0;
    localparam int unsigned REG_PRESC  = 1;
    localparam int unsigned CH_BASE    = 4;
    localparam int unsigned CH_STRIDE  = 4;
    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_PER   = 1;
    localparam int unsigned CTRL_IE    = 2;
    typedef enum logic [1:0] {
        CH_COUNT   = 2'd0,
        CH_COMPARE = 2'd1,
        CH_CTRL    = 2'd2,
        CH_STATUS  = 2'd3
    } ch_reg_e;
endpackage

// File: rtl/soc_timer_chan.sv
// soc_timer_chan: one compare timer (COUNT, COMPARE, CTRL, sticky MATCH).
// Ports: clk/rst (sync, active-low); i_tick prescaler tick; i_we_* decoded
// register write strobes with i_wdata; i_reg selects o_rdata; o_irq = MATCH & IE.
module soc_timer_chan
    import soc_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_we_count,
    input  logic             i_we_cmp,
    input  logic             i_we_ctrl,
    input  logic             i_we_stat,
    input  logic [WIDTH-1:0] i_wdata,
    input  ch_reg_e          i_reg,
    output logic [31:0]      o_rdata,
    output logic             o_irq
);
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_cmp;
    logic [2:0]       r_ctrl;
    logic             r_match;
    logic             w_run;
    logic             w_hit;

    always_comb begin
        w_run   = i_tick && r_ctrl[CTRL_EN];
        w_hit   = w_run && (r_count == r_cmp);
        o_irq   = r_match && r_ctrl[CTRL_IE];
        o_rdata = i_reg == CH_COUNT   ? 32'(r_count) :
                  i_reg == CH_COMPARE ? 32'(r_cmp)   :
                  i_reg == CH_CTRL    ? {29'd0, r_ctrl} : {31'd0, r_match};
    end

    // CPU writes to COUNT/CTRL override the tick update; a match set
    // overrides a same-cycle STATUS clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
            r_cmp   <= '0;
            r_ctrl  <= '0;
            r_match <= 1'b0;
        end else begin
            if (i_we_count)
                r_count <= i_wdata;
            else if (w_hit)
                r_count <= r_ctrl[CTRL_PER] ? '0 : r_count;
            else if (w_run)
                r_count <= r_count + WIDTH'(1);
            if (i_we_cmp)
                r_cmp <= i_wdata;
            if (i_we_ctrl)
                r_ctrl <= i_wdata[2:0];
            else if (w_hit && !r_ctrl[CTRL_PER])
                r_ctrl[CTRL_EN] <= 1'b0;
            if (w_hit)
                r_match <= 1'b1;
            else if (i_we_stat && i_wdata[0])
                r_match <= 1'b0;
        end
    end
endmodule

// File: rtl/soc_timer_bank.sv
// soc_timer_bank: memory-mapped cycle counter, shared prescaler and NCHAN compare timers.
// Ports: clk/rst (sync, active-low); addr_b/data_b_in/data_b_we CPU data port;
// data_b/strobe_b registered read data and valid; irq registered OR of channel MATCH & IE.
module soc_timer_bank
    import soc_timer_pkg::*;
#(
    parameter int unsigned BASE    = 65542,
    parameter int unsigned NCHAN   = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned PRESC_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_b,
    input  logic [31:0] data_b_in,
    input  logic        data_b_we,
    output logic [31:0] data_b,
    output logic        strobe_b,
    output logic        irq
);
    localparam int unsigned NREG = CH_BASE + CH_STRIDE * NCHAN;

    logic [WIDTH-1:0]   r_cycles;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_pc;
    logic [31:0]        w_off;
    logic [31:0]        w_rd;
    logic [31:0]        w_ch_rd_sel;
    logic [2:0]         w_ch;
    ch_reg_e            w_reg;
    logic               w_hit;
    logic               w_is_ch;
    logic               w_map;
    logic               w_tick;
    logic               w_presc_we;
    logic [31:0]        w_ch_rd [NCHAN];
    logic [NCHAN-1:0]   w_ch_irq;
    logic [NCHAN-1:0]   w_ch_sel;

    // BASE+2/+3 sit inside the decoded window but are not mapped, so they
    // hit the window yet never raise strobe or write anything.
    always_comb begin
        w_off       = addr_b - BASE;
        w_hit       = (addr_b >= BASE) && (w_off < NREG);
        w_is_ch     = w_off >= CH_BASE;
        w_ch        = 3'((w_off - CH_BASE) >> 2);
        w_reg       = ch_reg_e'(w_off[1:0]);
        w_map       = w_hit && (w_is_ch || w_off == REG_CYCLES || w_off == REG_PRESC);
        w_tick      = r_pc == r_presc;
        w_presc_we  = data_b_we && w_hit && (w_off == REG_PRESC);
        w_ch_rd_sel = '0;
        for (int c = 0; c < NCHAN; c++)
            if (w_ch == 3'(c))
                w_ch_rd_sel = w_ch_rd[c];
        w_rd        = w_is_ch ? w_ch_rd_sel : w_off == REG_PRESC ? 32'(r_presc) : 32'(r_cycles);
    end

    for (genvar g = 0; g < NCHAN; g++) begin : g_ch
        assign w_ch_sel[g] = w_hit && w_is_ch && (w_ch == 3'(g));
        soc_timer_chan #(.WIDTH(WIDTH)) u_chan (
            .clk        (clk),
            .rst        (rst),
            .i_tick     (w_tick),
            .i_we_count (data_b_we && w_ch_sel[g] && w_reg == CH_COUNT),
            .i_we_cmp   (data_b_we && w_ch_sel[g] && w_reg == CH_COMPARE),
            .i_we_ctrl  (data_b_we && w_ch_sel[g] && w_reg == CH_CTRL),
            .i_we_stat  (data_b_we && w_ch_sel[g] && w_reg == CH_STATUS),
            .i_wdata    (data_b_in[WIDTH-1:0]),
            .i_reg      (w_reg),
            .o_rdata    (w_ch_rd[g]),
            .o_irq      (w_ch_irq[g])
        );
    end

    // Writing PRESC restarts the prescaler phase from 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cycles <= '0;
            r_presc  <= '0;
            r_pc     <= '0;
            data_b   <= '0;
            strobe_b <= 1'b0;
            irq      <= 1'b0;
        end else begin
            r_cycles <= r_cycles + WIDTH'(1);
            r_presc  <= w_presc_we ? data_b_in[PRESC_W-1:0] : r_presc;
            r_pc     <= (w_presc_we || w_tick) ? '0 : r_pc + PRESC_W'(1);
            data_b   <= w_map ? w_rd : '0;
            strobe_b <= w_map;
            irq      <= |w_ch_irq;
        end
    end
endmodule
